// File: rtl/lsu_riscv_pkg.sv
// Shared definitions for the load/store unit: access size encodings (funct3),
// FSM state type and fault cause codes.
package lsu_riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam logic LSU_FAULT_MISALIGN = 1'b0;
  localparam logic LSU_FAULT_TIMEOUT  = 1'b1;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align_riscv.sv
// Combinational lane logic: byte enables and replicated store data for a new
// request, misalignment/illegal-size detection, and load extraction/extension.
module lsu_align_riscv
  import lsu_riscv_pkg::*;
(
  input  logic [2:0]  st_size_i,
  input  logic [1:0]  st_offset_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = st_data_i;
    misalign_o = 1'b0;
    case (st_size_i)
      LDST_B, LDST_BU: begin
        be_o    = 4'b0001 << st_offset_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        be_o       = 4'b0011 << st_offset_i;
        wdata_o    = {2{st_data_i[15:0]}};
        misalign_o = st_offset_i[0];
      end
      LDST_W: begin
        be_o       = 4'b1111;
        misalign_o = (st_offset_i != 2'b00);
      end
      default: misalign_o = 1'b1;
    endcase
  end

  // The addressed byte/halfword is moved down to bit 0 before extension.
  always_comb begin
    shifted   = rdata_i >> {ld_offset_i, 3'b000};
    ld_data_o = shifted;
    case (ld_size_i)
      LDST_B:  ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      LDST_BU: ld_data_o = {24'h000000, shifted[7:0]};
      LDST_H:  ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      LDST_HU: ld_data_o = {16'h0000, shifted[15:0]};
      default: ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_riscv.sv
// Load/store controller: stalls the core while an access runs on the data bus,
// then reports the extended load result or a misalign/timeout fault for one cycle.
module lsu_riscv
  import lsu_riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_fault_o,
  output logic        lsu_fault_cause_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_ack_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  offset_q, offset_d;
  logic        data_req_q, data_req_d;
  logic        data_we_q, data_we_d;
  logic [3:0]  data_be_q, data_be_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [31:0] data_wdata_q, data_wdata_d;
  logic [31:0] lsu_data_q, lsu_data_d;
  logic        lsu_fault_q, lsu_fault_d;
  logic        lsu_cause_q, lsu_cause_d;

  logic [3:0]  new_be;
  logic [31:0] new_wdata;
  logic        new_misalign;
  logic [31:0] ld_data;

  // Load extraction uses the size/offset captured at request time, so a core
  // that misbehaves by dropping its request mid-access cannot corrupt the result.
  lsu_align_riscv u_align (
    .st_size_i   (lsu_size_i),
    .st_offset_i (lsu_addr_i[1:0]),
    .st_data_i   (lsu_data_i),
    .be_o        (new_be),
    .wdata_o     (new_wdata),
    .misalign_o  (new_misalign),
    .ld_size_i   (size_q),
    .ld_offset_i (offset_q),
    .rdata_i     (data_rdata_i),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    offset_d     = offset_q;
    data_req_d   = data_req_q;
    data_we_d    = data_we_q;
    data_be_d    = data_be_q;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;
    lsu_data_d   = lsu_data_q;
    lsu_fault_d  = lsu_fault_q;
    lsu_cause_d  = lsu_cause_q;
    case (state_q)
      LSU_IDLE: begin
        if (lsu_req_i) begin
          if (new_misalign) begin
            lsu_fault_d = 1'b1;
            lsu_cause_d = LSU_FAULT_MISALIGN;
            lsu_data_d  = 32'h0;
            state_d     = LSU_RESP;
          end else begin
            data_req_d   = 1'b1;
            data_we_d    = lsu_we_i;
            data_be_d    = new_be;
            data_addr_d  = {lsu_addr_i[31:2], 2'b00};
            data_wdata_d = new_wdata;
            size_d       = lsu_size_i;
            offset_d     = lsu_addr_i[1:0];
            cnt_d        = '0;
            state_d      = LSU_BUS;
          end
        end
      end
      LSU_BUS: begin
        if (data_ack_i) begin
          data_req_d = 1'b0;
          lsu_data_d = data_we_q ? 32'h0 : ld_data;
          state_d    = LSU_RESP;
        end else if (cnt_q == CNT_MAX) begin
          data_req_d  = 1'b0;
          lsu_fault_d = 1'b1;
          lsu_cause_d = LSU_FAULT_TIMEOUT;
          lsu_data_d  = 32'h0;
          state_d     = LSU_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LSU_RESP: begin
        lsu_fault_d = 1'b0;
        lsu_cause_d = 1'b0;
        state_d     = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= '0;
      size_q       <= 3'b000;
      offset_q     <= 2'b00;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= 4'b0000;
      data_addr_q  <= 32'h0;
      data_wdata_q <= 32'h0;
      lsu_data_q   <= 32'h0;
      lsu_fault_q  <= 1'b0;
      lsu_cause_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      offset_q     <= offset_d;
      data_req_q   <= data_req_d;
      data_we_q    <= data_we_d;
      data_be_q    <= data_be_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      lsu_data_q   <= lsu_data_d;
      lsu_fault_q  <= lsu_fault_d;
      lsu_cause_q  <= lsu_cause_d;
    end
  end

  assign lsu_stall_req_o   = lsu_req_i && (state_q != LSU_RESP);
  assign lsu_data_o        = lsu_data_q;
  assign lsu_fault_o       = lsu_fault_q;
  assign lsu_fault_cause_o = lsu_cause_q;
  assign data_req_o        = data_req_q;
  assign data_we_o         = data_we_q;
  assign data_be_o         = data_be_q;
  assign data_addr_o       = data_addr_q;
  assign data_wdata_o      = data_wdata_q;

endmodule

// File: tb/tb_lsu_riscv.sv
// Scoreboard bench for lsu_riscv: a default-timeout instance for normal accesses
// and a TIMEOUT_CYCLES=4 instance for the bus timeout case.
module tb_lsu_riscv;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic        cause;
    int          stall_n;
    int          bus_n;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        lsu_req = 1'b0;
  logic        to_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_size = 3'b000;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic [31:0] data_rdata = 32'h0;
  logic        data_ack = 1'b0;

  logic        stall, fault, cause, dreq, dwe;
  logic [31:0] ldata, daddr, dwdata;
  logic [3:0]  dbe;
  logic        to_stall, to_fault, to_cause, to_dreq, to_dwe;
  logic [31:0] to_ldata, to_daddr, to_dwdata;
  logic [3:0]  to_dbe;

  int errors = 0;
  int checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  lsu_riscv dut (
    .clk_i(clk), .arstn_i(arstn), .lsu_req_i(lsu_req), .lsu_we_i(lsu_we),
    .lsu_size_i(lsu_size), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_wdata),
    .lsu_stall_req_o(stall), .lsu_data_o(ldata), .lsu_fault_o(fault),
    .lsu_fault_cause_o(cause), .data_req_o(dreq), .data_we_o(dwe),
    .data_be_o(dbe), .data_addr_o(daddr), .data_wdata_o(dwdata),
    .data_rdata_i(data_rdata), .data_ack_i(data_ack)
  );

  lsu_riscv #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .arstn_i(arstn), .lsu_req_i(to_req), .lsu_we_i(lsu_we),
    .lsu_size_i(lsu_size), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_wdata),
    .lsu_stall_req_o(to_stall), .lsu_data_o(to_ldata), .lsu_fault_o(to_fault),
    .lsu_fault_cause_o(to_cause), .data_req_o(to_dreq), .data_we_o(to_dwe),
    .data_be_o(to_dbe), .data_addr_o(to_daddr), .data_wdata_o(to_dwdata),
    .data_rdata_i(data_rdata), .data_ack_i(data_ack)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference behaviour written from the access rules, independent of the RTL structure.
  function automatic exp_t modelAccess(input logic we, input logic [2:0] size,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       input logic [31:0] rd, input int ack_cycle,
                                       input bit use_to);
    exp_t e;
    int off;
    logic [7:0] b;
    logic [15:0] h;
    bit bad;
    off = int'(addr[1:0]);
    bad = !(size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
          ((size == 3'd1 || size == 3'd5) && addr[0]) ||
          (size == 3'd2 && addr[1:0] != 2'b00);
    e.we = we;
    e.addr = {addr[31:2], 2'b00};
    e.be = 4'b0000;
    e.wdata = wd;
    if (size == 3'd0 || size == 3'd4) begin
      e.be = 4'(1 << off);
      e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    end else if (size == 3'd1 || size == 3'd5) begin
      e.be = 4'(3 << off);
      e.wdata = {wd[15:0], wd[15:0]};
    end else if (size == 3'd2) begin
      e.be = 4'hF;
    end
    e.data = 32'h0;
    e.fault = 1'b0;
    e.cause = 1'b0;
    if (bad) begin
      e.fault = 1'b1;
      e.bus_n = 0;
      e.stall_n = 1;
    end else if (ack_cycle == 0) begin
      e.fault = 1'b1;
      e.cause = 1'b1;
      e.bus_n = use_to ? 4 : 255;
      e.stall_n = e.bus_n + 1;
    end else begin
      e.bus_n = ack_cycle;
      e.stall_n = ack_cycle + 1;
      b = rd[8*off +: 8];
      h = (off >= 2) ? rd[31:16] : rd[15:0];
      if (!we) begin
        case (size)
          3'd0: e.data = {{24{b[7]}}, b};
          3'd4: e.data = {24'h0, b};
          3'd1: e.data = {{16{h[15]}}, h};
          3'd5: e.data = {16'h0, h};
          default: e.data = rd;
        endcase
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input string name, input logic we, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rd, input int ack_cycle, input bit use_to);
    exp_t e;
    int stall_n = 0;
    int bus_n = 0;
    bit done = 0;
    logic s_stall, s_req, s_fault, s_cause, c_we;
    logic [31:0] s_data, c_addr, c_wdata;
    logic [3:0] c_be;
    c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_be = 4'h0;
    s_data = 32'h0; s_fault = 1'b0; s_cause = 1'b0;
    sb_q.push_back(modelAccess(we, size, addr, wd, rd, ack_cycle, use_to));
    @(negedge clk);
    lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wdata = wd; data_rdata = rd;
    if (use_to) to_req = 1'b1; else lsu_req = 1'b1;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      #1;
      data_ack = 1'b0;
      s_stall = use_to ? to_stall : stall;
      s_req   = use_to ? to_dreq : dreq;
      if (s_stall) stall_n++;
      if (s_req) begin
        bus_n++;
        c_we    = use_to ? to_dwe : dwe;
        c_be    = use_to ? to_dbe : dbe;
        c_addr  = use_to ? to_daddr : daddr;
        c_wdata = use_to ? to_dwdata : dwdata;
        if (bus_n == ack_cycle) data_ack = 1'b1;
      end
      if (!s_stall) begin
        s_data  = use_to ? to_ldata : ldata;
        s_fault = use_to ? to_fault : fault;
        s_cause = use_to ? to_cause : cause;
        lsu_req = 1'b0;
        to_req  = 1'b0;
        done    = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checkOutput({name, ".resp_wait"}, 32'd0, 32'd1);
      lsu_req = 1'b0;
      to_req = 1'b0;
    end
    e = sb_q.pop_front();
    checkOutput({name, ".stall_cycles"}, 32'(stall_n), 32'(e.stall_n));
    checkOutput({name, ".bus_cycles"}, 32'(bus_n), 32'(e.bus_n));
    checkOutput({name, ".lsu_data"}, s_data, e.data);
    checkOutput({name, ".fault"}, {31'h0, s_fault}, {31'h0, e.fault});
    if (e.fault) checkOutput({name, ".cause"}, {31'h0, s_cause}, {31'h0, e.cause});
    if (e.bus_n > 0) begin
      checkOutput({name, ".be"}, {28'h0, c_be}, {28'h0, e.be});
      checkOutput({name, ".addr"}, c_addr, e.addr);
      checkOutput({name, ".we"}, {31'h0, c_we}, {31'h0, e.we});
      if (e.we) checkOutput({name, ".wdata"}, c_wdata, e.wdata);
    end
  endtask

  initial begin
    int bus_n;
    #1;
    checkOutput("rst.data_req", {31'h0, dreq}, 32'h0);
    checkOutput("rst.be", {28'h0, dbe}, 32'h0);
    checkOutput("rst.addr", daddr, 32'h0);
    checkOutput("rst.lsu_data", ldata, 32'h0);
    checkOutput("rst.fault", {31'h0, fault}, 32'h0);
    lsu_req = 1'b1;
    #1;
    checkOutput("rst.stall_idle", {31'h0, stall}, 32'h1);
    lsu_req = 1'b0;
    @(negedge clk);
    arstn = 1'b1;

    applyStimulus("lw_100", 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0);
    applyStimulus("lb_103", 1'b0, 3'd0, 32'h103, 32'h0, 32'h80123456, 1, 0);
    applyStimulus("lbu_103", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80123456, 1, 0);
    applyStimulus("lh_102", 1'b0, 3'd1, 32'h102, 32'h0, 32'h80011234, 2, 0);
    applyStimulus("lhu_100", 1'b0, 3'd5, 32'h100, 32'h0, 32'h80019234, 1, 0);
    applyStimulus("sh_202", 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 5, 0);
    applyStimulus("sb_101", 1'b1, 3'd0, 32'h101, 32'h12345678, 32'h0, 2, 0);
    applyStimulus("sbu_302", 1'b1, 3'd4, 32'h302, 32'h000000A5, 32'h0, 1, 0);
    applyStimulus("lw_101", 1'b0, 3'd2, 32'h101, 32'h0, 32'h11111111, 1, 0);
    applyStimulus("sh_203", 1'b1, 3'd1, 32'h203, 32'h0000ABCD, 32'h0, 1, 0);
    applyStimulus("ld_size3", 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1, 0);
    applyStimulus("lw_timeout", 1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 0, 1);

    // Abort an access in its second bus cycle with an asynchronous reset.
    @(negedge clk);
    lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h500; lsu_req = 1'b1;
    bus_n = 0;
    for (int i = 0; i < 10 && bus_n < 2; i++) begin
      #1;
      if (dreq) bus_n++;
      if (bus_n < 2) @(negedge clk);
    end
    checkOutput("abort.reached_bus2", 32'(bus_n), 32'd2);
    arstn = 1'b0;
    #1;
    checkOutput("abort.data_req", {31'h0, dreq}, 32'h0);
    checkOutput("abort.lsu_data", ldata, 32'h0);
    checkOutput("abort.fault", {31'h0, fault}, 32'h0);
    checkOutput("abort.stall_idle", {31'h0, stall}, 32'h1);
    lsu_req = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    applyStimulus("post_lw", 1'b0, 3'd2, 32'h600, 32'h0, 32'hCAFEF00D, 1, 0);
    applyStimulus("post_sw", 1'b1, 3'd2, 32'h604, 32'h01020304, 32'h0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_riscv.md
Name: lsu_riscv

Overview:
- Load/store controller between the core's execute stage and the data memory bus.
- Sequences each access requested by the decoder (mem_req/mem_we/mem_size):
  - stalls the core for the access,
  - drives byte enables and lane-replicated write data,
  - aligns and sign- or zero-extends read data,
  - reports misalignment and bus-timeout faults.
- Sits in the core top beside the ALU; lsu_data_o feeds the WB_LSU_DATA writeback mux input.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUS-state cycles waiting for data_ack_i before a timeout fault (must be >= 1).

Ports:
- clk_i  input  1  clock
- arstn_i  input  1  asynchronous active-low reset
- lsu_req_i  input  1  access request from decoder mem_req_o; held stable while lsu_stall_req_o=1
- lsu_we_i  input  1  1=store, 0=load
- lsu_size_i  input  3  LDST_B/H/W/BU/HU encoding (funct3)
- lsu_addr_i  input  32  byte address (ALU result)
- lsu_data_i  input  32  store data (rs2)
- lsu_stall_req_o  output  1  core stall
- lsu_data_o  output  32  extended load result, valid in RESP
- lsu_fault_o  output  1  fault pulse, valid in RESP
- lsu_fault_cause_o  output  1  0=misaligned/illegal size, 1=timeout
- data_req_o  output  1  bus request
- data_we_o  output  1  bus write
- data_be_o  output  4  byte enables
- data_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
- data_wdata_o  output  32  write data
- data_rdata_i  input  32  read data, valid with data_ack_i
- data_ack_i  input  1  bus completion

Behaviour:
- Reset (arstn_i low, asynchronous): state=IDLE, counter=0. All registered outputs are 0: data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, lsu_data_o, lsu_fault_o, lsu_fault_cause_o.
- Reset mid-transaction aborts it immediately. No result or fault is reported.
- FSM states: IDLE, BUS, RESP.
- lsu_stall_req_o = lsu_req_i && (state != RESP). This is the only combinational output.
- IDLE, lsu_req_i=1, aligned and legal:
  - Register data_req_o=1, data_we_o, data_be_o, data_addr_o, data_wdata_o.
  - Clear counter, go to BUS.
- IDLE, lsu_req_i=1, misaligned or illegal:
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal size means a load with size 3/6/7, or a store with size 3/6/7.
  - Go to RESP with lsu_fault_o=1, cause=0, lsu_data_o=0. No bus request is issued.
- Store with BU/HU is treated as B/H.
- BUS:
  - data_req_o is held high with all bus outputs stable.
  - On data_ack_i:
    - data_req_o=0.
    - For loads, lsu_data_o = extend(data_rdata_i >> 8*addr[1:0]). Stores leave lsu_data_o=0.
    - Go to RESP.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: data_req_o=0, lsu_fault_o=1, cause=1, lsu_data_o=0, go to RESP.
  - Otherwise counter+1.
- RESP:
  - Stall is released for exactly one cycle. The core retires the instruction at this edge.
  - lsu_fault_o/cause are cleared on exit. lsu_data_o is held until the next RESP.
  - Always go to IDLE. A lsu_req_i still high in RESP belongs to the retiring instruction and is ignored.
- Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<addr[1:0]; W 4'b1111.
- Write data lanes: B {4{d[7:0]}}; H {2{d[15:0]}}; W d.
- Read extension: B sign-extends bits [7:0]; BU zero-extends them. H sign-extends [15:0]; HU zero-extends them. W is passed through.
- Minimum access: the stall is high for 2 cycles (IDLE, BUS with ack) and low in the 3rd (RESP). A fault: the stall is high for 1 cycle, then RESP.
- data_ack_i outside BUS is ignored.
- lsu_req_i dropping while in BUS is illegal core behaviour. The bus access still completes and the stall follows lsu_req_i.

Decomposition:
- Shared package/defines: LDST_* size encodings (already in the defines header), FSM state typedef (lsu_state_t), fault cause constants (LSU_FAULT_MISALIGN=0, LSU_FAULT_TIMEOUT=1).
- One sub-module, lsu_align_riscv: combinational. It generates BE and write lanes from size/addr/data, performs load extraction/extension, and produces the misaligned/illegal flag. The FSM, counter and registers stay in lsu_riscv.

Test Plan:
- LW, addr 0x100, rdata 0xDEADBEEF, ack in the first BUS cycle → data_addr_o=0x100, be=1111, stall for 2 cycles, lsu_data_o=0xDEADBEEF in RESP, no fault.
- LB, addr 0x103, rdata 0x80123456 → be=1000, lsu_data_o=0xFFFFFF80. LBU with the same inputs → 0x00000080.
- SH, addr 0x202, data 0x0000ABCD, ack after 5 cycles → data_wdata_o=0xABCDABCD, be=1100, we=1, stall for 6 cycles, then release.
- LW, addr 0x101 → no data_req_o, RESP with lsu_fault_o=1, cause=0, lsu_data_o=0, stall for 1 cycle. SH, addr 0x203 → same.
- TIMEOUT_CYCLES=4, LW with no ack → data_req_o high for 4 cycles, then RESP with fault=1, cause=1.
- Reset asserted in the 2nd BUS cycle → data_req_o=0 and state=IDLE immediately. After release, a back-to-back LW then SW complete normally.
